// File: rtl/mac_stat_ctrl_if.sv
// MAC statistics bus: RX/TX descriptor handshakes and the
// byte-serial management request/response path.
// master: MAC/SPI side driving descriptors and requests.
// slave : statistics block answering resp and read bytes.
interface mac_stat_ctrl_if #(
   parameter int LEN_W     = 12,
   parameter int RX_FLAG_W = 8,
   parameter int TX_FLAG_W = 4
);
   logic                       rx_mgnt_valid;
   logic                       rx_mgnt_resp;
   logic [RX_FLAG_W+LEN_W-1:0] rx_mgnt_data;
   logic                       tx_mgnt_valid;
   logic                       tx_mgnt_resp;
   logic [TX_FLAG_W+LEN_W-1:0] tx_mgnt_data;
   logic                       sys_req_valid;
   logic                       sys_req_wr;
   logic [7:0]                 sys_req_addr;
   logic                       sys_resp_valid;
   logic [7:0]                 sys_resp_data;

   modport master (
      output rx_mgnt_valid, rx_mgnt_data,
      input  rx_mgnt_resp,
      output tx_mgnt_valid, tx_mgnt_data,
      input  tx_mgnt_resp,
      output sys_req_valid, sys_req_wr,
      output sys_req_addr,
      input  sys_resp_valid, sys_resp_data
   );

   modport slave (
      input  rx_mgnt_valid, rx_mgnt_data,
      output rx_mgnt_resp,
      input  tx_mgnt_valid, tx_mgnt_data,
      output tx_mgnt_resp,
      input  sys_req_valid, sys_req_wr,
      input  sys_req_addr,
      output sys_resp_valid, sys_resp_data
   );
endinterface

// File: rtl/mac_stat_ctrl.sv
// MAC statistics: per-direction counter banks fed by
// synchronised descriptor handshakes, read byte-serially.
// Ports: clk_if, rstn_if (async low), bus (slave modport):
//  rx/tx_mgnt_valid/data in, rx/tx_mgnt_resp out,
//  sys_req_valid/wr/addr in, sys_resp_valid/data out.

module mac_stat_bank #(
   parameter int CNT_W     = 32,
   parameter int LEN_W     = 12,
   parameter int FLAG_W    = 8,
   parameter int ERR_W     = 4,
   parameter int SYNC_STG  = 4,
   parameter bit SAT_EN    = 1'b1,
   parameter bit CLR_ON_RD = 1'b0
) (
   input  logic                    clk_if,
   input  logic                    rstn_if,
   input  logic                    valid,
   input  logic [FLAG_W+LEN_W-1:0] data,
   output logic                    resp,
   input  logic                    clr,
   input  logic                    rd_take,
   input  logic [3:0]              rd_idx,
   output logic [CNT_W-1:0]        rd_val
);
   localparam int NC = 2 + FLAG_W;

   typedef enum logic [1:0] {
      S_IDLE, S_CAPT, S_UPD, S_RESP
   } st_t;

   st_t                     st_q, st_d;
   logic [SYNC_STG-1:0]     sync_q;
   logic [FLAG_W+LEN_W-1:0] desc_q;
   logic                    resp_q, resp_d;
   logic                    cap, upd, ok;
   logic [FLAG_W-1:0]       flags;
   logic [LEN_W-1:0]        len;
   logic [CNT_W-1:0]        cnt_q [NC];
   logic [CNT_W-1:0]        inc   [NC];

   function automatic logic [CNT_W-1:0] add_sat(
      input logic [CNT_W-1:0] a,
      input logic [CNT_W-1:0] b
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (SAT_EN && s[CNT_W]) return '1;
      return s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk_if or negedge rstn_if) begin
      if (!rstn_if) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STG-2:0], valid};
   end

   always_ff @(posedge clk_if or negedge rstn_if) begin
      if (!rstn_if) st_q <= S_IDLE;
      else st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         S_IDLE: if (&sync_q) st_d = S_CAPT;
         S_CAPT: st_d = S_UPD;
         S_UPD:  st_d = S_RESP;
         S_RESP: if (!sync_q[SYNC_STG-1]) st_d = S_IDLE;
         default: st_d = S_IDLE;
      endcase
   end

   always_comb begin
      cap    = (st_q == S_IDLE) && (st_d == S_CAPT);
      upd    = (st_q == S_UPD);
      resp_d = (st_d == S_RESP);
   end

   always_ff @(posedge clk_if or negedge rstn_if) begin
      if (!rstn_if) begin
         resp_q <= 1'b0;
         desc_q <= '0;
      end else begin
         resp_q <= resp_d;
         if (cap) desc_q <= data;
      end
   end

   assign resp  = resp_q;
   assign flags = desc_q[FLAG_W+LEN_W-1 -: FLAG_W];
   assign len   = desc_q[LEN_W-1:0];
   // error flags sit at the top; a zero-width
   // error field shifts everything out
   assign ok    = ~|(flags >> (FLAG_W - ERR_W));

   always_comb begin
      for (int i = 0; i < NC; i++) inc[i] = '0;
      if (upd) begin
         inc[0] = CNT_W'(ok);
         inc[1] = ok ? CNT_W'(len) : '0;
         for (int k = 0; k < FLAG_W; k++)
            inc[2+k] = CNT_W'(flags[k]);
      end
   end

   // clear beats update; a clear-on-read keeps
   // only the increment landing in the same cycle
   always_ff @(posedge clk_if or negedge rstn_if) begin
      if (!rstn_if) begin
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            if (CLR_ON_RD && rd_take && rd_idx == 4'(i))
               cnt_q[i] <= inc[i];
            else
               cnt_q[i] <= add_sat(cnt_q[i], inc[i]);
         end
      end
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NC; i++)
         if (rd_idx == 4'(i)) rd_val = cnt_q[i];
   end
endmodule

module mac_stat_ctrl #(
   parameter int CNT_W     = 32,
   parameter int LEN_W     = 12,
   parameter int RX_FLAG_W = 8,
   parameter int RX_ERR_W  = 4,
   parameter int TX_FLAG_W = 4,
   parameter int SYNC_STG  = 4,
   parameter bit SAT_EN    = 1'b1,
   parameter bit CLR_ON_RD = 1'b0
) (
   input logic            clk_if,
   input logic            rstn_if,
   mac_stat_ctrl_if.slave bus
);
   localparam int NB  = CNT_W / 8;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      M_IDLE, M_DEC, M_RD, M_WR
   } mst_t;

   mst_t             m_q, m_d;
   logic             wr_q;
   logic [7:0]       addr_q;
   logic [CNT_W-1:0] sh_q;
   logic [BCW-1:0]   bcnt_q;
   logic             rv_q;
   logic [7:0]       rd_q;
   logic             ld_req, take, shift;
   logic             clr_rx, clr_tx;
   logic             take_rx, take_tx;
   logic             rx_resp, tx_resp;
   logic [CNT_W-1:0] rx_val, tx_val, sel_val;

   mac_stat_bank #(
      .CNT_W(CNT_W), .LEN_W(LEN_W),
      .FLAG_W(RX_FLAG_W), .ERR_W(RX_ERR_W),
      .SYNC_STG(SYNC_STG), .SAT_EN(SAT_EN),
      .CLR_ON_RD(CLR_ON_RD)
   ) u_rx (
      .clk_if (clk_if),
      .rstn_if(rstn_if),
      .valid  (bus.rx_mgnt_valid),
      .data   (bus.rx_mgnt_data),
      .resp   (rx_resp),
      .clr    (clr_rx),
      .rd_take(take_rx),
      .rd_idx (addr_q[3:0]),
      .rd_val (rx_val)
   );

   mac_stat_bank #(
      .CNT_W(CNT_W), .LEN_W(LEN_W),
      .FLAG_W(TX_FLAG_W), .ERR_W(0),
      .SYNC_STG(SYNC_STG), .SAT_EN(SAT_EN),
      .CLR_ON_RD(CLR_ON_RD)
   ) u_tx (
      .clk_if (clk_if),
      .rstn_if(rstn_if),
      .valid  (bus.tx_mgnt_valid),
      .data   (bus.tx_mgnt_data),
      .resp   (tx_resp),
      .clr    (clr_tx),
      .rd_take(take_tx),
      .rd_idx (addr_q[3:0]),
      .rd_val (tx_val)
   );

   assign bus.rx_mgnt_resp = rx_resp;
   assign bus.tx_mgnt_resp = tx_resp;
   assign sel_val = addr_q[4] ? tx_val : rx_val;

   always_ff @(posedge clk_if or negedge rstn_if) begin
      if (!rstn_if) m_q <= M_IDLE;
      else m_q <= m_d;
   end

   always_comb begin
      m_d = m_q;
      unique case (m_q)
         M_IDLE: if (bus.sys_req_valid) m_d = M_DEC;
         M_DEC:  m_d = wr_q ? M_WR : M_RD;
         M_RD:   if (bcnt_q == '0) m_d = M_IDLE;
         M_WR:   m_d = M_IDLE;
         default: m_d = M_IDLE;
      endcase
   end

   always_comb begin
      ld_req  = (m_q == M_IDLE) && bus.sys_req_valid;
      take    = (m_q == M_DEC) && !wr_q;
      shift   = (m_q == M_RD);
      clr_rx  = (m_q == M_WR) && (addr_q == 8'h0F);
      clr_tx  = (m_q == M_WR) && (addr_q == 8'h1F);
      take_rx = take && !addr_q[4];
      take_tx = take && addr_q[4];
   end

   // snapshot loads the first byte straight into the
   // output register; the rest shift out MSB first
   always_ff @(posedge clk_if or negedge rstn_if) begin
      if (!rstn_if) begin
         wr_q   <= 1'b0;
         addr_q <= '0;
         sh_q   <= '0;
         bcnt_q <= '0;
         rv_q   <= 1'b0;
         rd_q   <= '0;
      end else begin
         if (ld_req) begin
            wr_q   <= bus.sys_req_wr;
            addr_q <= bus.sys_req_addr;
         end
         if (take) begin
            sh_q   <= sel_val << 8;
            rd_q   <= sel_val[CNT_W-1 -: 8];
            rv_q   <= 1'b1;
            bcnt_q <= BCW'(NB - 1);
         end else if (shift) begin
            if (bcnt_q == '0) begin
               rv_q <= 1'b0;
               rd_q <= '0;
            end else begin
               rd_q   <= sh_q[CNT_W-1 -: 8];
               sh_q   <= sh_q << 8;
               bcnt_q <= bcnt_q - BCW'(1);
            end
         end
      end
   end

   assign bus.sys_resp_valid = rv_q;
   assign bus.sys_resp_data  = rd_q;
endmodule
